// File: rtl/elevator_pkg.sv
// Shared parameters and types for the per-car floor request queue.
// Imported by the decoder and the queue top.
package elevator_pkg;

  localparam int NUM_FLOORS   = 7;
  localparam int FLOOR_W      = 3;
  localparam int DOOR_TIMEOUT = 255;
  localparam int TMR_W        = $clog2(DOOR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    SERVICE
  } req_q_state_t;

  typedef logic [NUM_FLOORS-1:0] floor_mask_t;

endpackage

// File: rtl/elevator_floor_decoder.sv
// Floor index to one-hot floor mask, with range flag.
// Out-of-range indices produce an all-zero mask.
module elevator_floor_decoder
  import elevator_pkg::*;
(
  input  logic [FLOOR_W-1:0] i_floor,
  output floor_mask_t        o_mask,
  output logic               o_in_range
);

  assign o_in_range = 32'(i_floor) < NUM_FLOORS;
  assign o_mask     = o_in_range
                    ? (floor_mask_t'(1) << i_floor)
                    : '0;

endmodule

// File: rtl/elevator_request_queue.sv
// Per-car floor request queue: call capture, arrival detect,
// stop request through the door cycle, and door timeout fault.
module elevator_request_queue
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  output logic               req_err,
  input  logic [FLOOR_W-1:0] car_floor,
  input  logic               car_floor_stb,
  input  logic               door_done,
  output floor_mask_t        queue_status,
  output logic               queue_empty,
  output logic               stop_req,
  output logic               door_fault
);

  req_q_state_t     r_state;
  floor_mask_t      r_queue;
  logic [TMR_W-1:0] r_timer;
  logic             r_stop;
  logic             r_ready;
  logic             r_err;
  logic             r_fault;

  floor_mask_t w_req_mask;
  floor_mask_t w_car_mask;
  floor_mask_t w_set;
  floor_mask_t w_clr;
  floor_mask_t w_q_nxt;
  logic        w_req_in;
  logic        w_car_in;
  logic        w_acc;
  logic        w_same;
  logic        w_car_hit;
  logic        w_exp;
  logic        w_exit;

  elevator_floor_decoder u_req_dec (
    .i_floor    (req_floor),
    .o_mask     (w_req_mask),
    .o_in_range (w_req_in)
  );

  elevator_floor_decoder u_car_dec (
    .i_floor    (car_floor),
    .o_mask     (w_car_mask),
    .o_in_range (w_car_in)
  );

  assign w_acc     = req_valid & r_ready;
  assign w_same    = w_req_in & (req_floor == car_floor);
  assign w_car_hit = w_car_in & (|(r_queue & w_car_mask));
  assign w_exp     = r_timer == TMR_W'(DOOR_TIMEOUT - 1);
  assign w_exit    = (r_state == SERVICE) & (door_done | w_exp);

  // A call for the floor the car is standing at is absorbed, not stored
  always_comb begin
    w_set = '0;
    if (w_acc && w_req_in) begin
      unique case (r_state)
        IDLE:    if (!w_same) w_set = w_req_mask;
        ACTIVE:  w_set = w_req_mask;
        SERVICE: if (!w_same) w_set = w_req_mask;
        default: w_set = '0;
      endcase
    end
  end

  assign w_clr   = w_exit ? w_car_mask : '0;
  assign w_q_nxt = (r_queue | w_set) & ~w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_queue <= '0;
      r_timer <= '0;
      r_stop  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_acc & ~w_req_in;
      r_queue <= w_q_nxt;
      unique case (r_state)
        IDLE: begin
          if (w_acc && w_req_in) begin
            if (w_same) begin
              r_state <= SERVICE;
              r_stop  <= 1'b1;
              r_timer <= '0;
            end else begin
              r_state <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (car_floor_stb && w_car_hit) begin
            r_state <= SERVICE;
            r_stop  <= 1'b1;
            r_timer <= '0;
          end
        end
        SERVICE: begin
          if (w_exit) begin
            r_stop  <= 1'b0;
            r_state <= (|w_q_nxt) ? ACTIVE : IDLE;
            if (w_exp && !door_done) r_fault <= 1'b1;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_stop  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = r_ready;
  assign req_err      = r_err;
  assign queue_status = r_queue;
  assign queue_empty  = ~|r_queue;
  assign stop_req     = r_stop;
  assign door_fault   = r_fault;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Bench for elevator_request_queue: directed scenarios plus
// randomized traffic against a behavioural queue model.
module tb_elevator_request_queue;

  localparam int NF  = 7;
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_floor;
  logic       req_ready;
  logic       req_err;
  logic [2:0] car_floor;
  logic       car_floor_stb;
  logic       door_done;
  logic [6:0] queue_status;
  logic       queue_empty;
  logic       stop_req;
  logic       door_fault;

  int n_chk = 0;
  int n_err = 0;

  bit [6:0] m_q;
  bit       m_serv;
  int       m_wait;
  bit       m_ready;
  bit       m_err;
  bit       m_fault;

  always #5 clk = ~clk;

  elevator_request_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .req_ready     (req_ready),
    .req_err       (req_err),
    .car_floor     (car_floor),
    .car_floor_stb (car_floor_stb),
    .door_done     (door_done),
    .queue_status  (queue_status),
    .queue_empty   (queue_empty),
    .stop_req      (stop_req),
    .door_fault    (door_fault)
  );

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, a, e, $time);
    end
  endtask

  // Pending set, in-service flag and wait count describe the car
  always @(posedge clk or negedge rst_n) begin : model
    bit [6:0] q;
    bit       sv;
    bit       ac;
    bit       inr;
    bit       tmo;
    bit       f;
    int       w;
    if (!rst_n) begin
      m_q     <= '0;
      m_serv  <= 1'b0;
      m_wait  <= 0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_fault <= 1'b0;
    end else begin
      q   = m_q;
      sv  = m_serv;
      w   = m_wait;
      f   = m_fault;
      ac  = req_valid && m_ready;
      inr = ac && (int'(req_floor) < NF);
      if (!sv) begin
        if (inr && m_q == 0 && req_floor == car_floor) begin
          sv = 1'b1;
          w  = 0;
        end else if (inr) begin
          q[req_floor] = 1'b1;
        end
        if (m_q != 0 && car_floor_stb && int'(car_floor) < NF
            && m_q[car_floor]) begin
          sv = 1'b1;
          w  = 0;
        end
      end else begin
        if (inr && req_floor != car_floor) q[req_floor] = 1'b1;
        w   = w + 1;
        tmo = (w == TMO);
        if (door_done || tmo) begin
          if (int'(car_floor) < NF) q[car_floor] = 1'b0;
          sv = 1'b0;
          if (tmo && !door_done) f = 1'b1;
        end
      end
      m_q     <= q;
      m_serv  <= sv;
      m_wait  <= w;
      m_fault <= f;
      m_err   <= ac && (int'(req_floor) >= NF);
      m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("queue_status", 32'(queue_status), 32'(m_q));
    chk("queue_empty", 32'(queue_empty), 32'(m_q == 0));
    chk("stop_req", 32'(stop_req), 32'(m_serv));
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("req_err", 32'(req_err), 32'(m_err));
    chk("door_fault", 32'(door_fault), 32'(m_fault));
  end

  task automatic cyc(input bit v, input int f, input bit s,
                     input int cf, input bit d);
    req_valid     = v;
    req_floor     = 3'(f);
    car_floor_stb = s;
    car_floor     = 3'(cf);
    door_done     = d;
    @(negedge clk);
    req_valid     = 1'b0;
    car_floor_stb = 1'b0;
    door_done     = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q"}, 32'(queue_status), 0);
    chk({tag, "_empty"}, 32'(queue_empty), 1);
    chk({tag, "_stop"}, 32'(stop_req), 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_err"}, 32'(req_err), 0);
    chk({tag, "_fault"}, 32'(door_fault), 0);
  endtask

  int cur;

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_floor     = '0;
    car_floor     = '0;
    car_floor_stb = 1'b0;
    door_done     = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_up", 32'(req_ready), 1);

    cyc(1, 4, 0, 0, 0);
    chk("t1_q", 32'(queue_status), 32'h10);
    chk("t1_empty", 32'(queue_empty), 0);

    cyc(1, 2, 0, 0, 0);
    cyc(1, 5, 0, 0, 0);
    chk("t2_q", 32'(queue_status), 32'h34);
    cyc(0, 0, 1, 2, 0);
    chk("t2_stop", 32'(stop_req), 1);
    cyc(0, 0, 0, 2, 0);
    chk("t2_hold", 32'(stop_req), 1);
    cyc(0, 0, 0, 2, 1);
    chk("t2_clr2", 32'(queue_status), 32'h30);
    chk("t2_stop0", 32'(stop_req), 0);
    cyc(0, 0, 1, 5, 0);
    cyc(0, 0, 0, 5, 1);
    chk("t2_clr5", 32'(queue_status), 32'h10);
    cyc(0, 0, 1, 4, 0);
    cyc(0, 0, 0, 4, 1);
    chk("t2_q0", 32'(queue_status), 0);
    chk("t2_empty", 32'(queue_empty), 1);

    cyc(1, 3, 0, 3, 0);
    chk("t3_stop", 32'(stop_req), 1);
    chk("t3_q0", 32'(queue_status), 0);
    cyc(1, 3, 0, 3, 0);
    chk("t3_absorb", 32'(queue_status), 0);
    cyc(1, 6, 0, 3, 1);
    chk("t3_q6", 32'(queue_status), 32'h40);
    chk("t3_stop0", 32'(stop_req), 0);

    cyc(1, 7, 0, 3, 0);
    chk("t4_err", 32'(req_err), 1);
    chk("t4_q", 32'(queue_status), 32'h40);
    cyc(0, 0, 0, 3, 0);
    chk("t4_err0", 32'(req_err), 0);
    cyc(1, 1, 0, 3, 0);
    chk("t4_q1", 32'(queue_status), 32'h42);
    cyc(1, 1, 0, 3, 0);
    chk("t4_dup", 32'(queue_status), 32'h42);

    cyc(0, 0, 1, 1, 0);
    chk("t5_stop", 32'(stop_req), 1);
    repeat (TMO - 1) cyc(0, 0, 0, 1, 0);
    chk("t5_pre_stop", 32'(stop_req), 1);
    chk("t5_pre_fault", 32'(door_fault), 0);
    cyc(0, 0, 0, 1, 0);
    chk("t5_stop0", 32'(stop_req), 0);
    chk("t5_fault", 32'(door_fault), 1);
    chk("t5_q", 32'(queue_status), 32'h40);
    cyc(0, 0, 0, 1, 1);
    chk("t5_sticky", 32'(door_fault), 1);
    cyc(0, 0, 1, 6, 0);
    cyc(0, 0, 0, 6, 1);
    chk("t5_q0", 32'(queue_status), 0);
    chk("t5_sticky2", 32'(door_fault), 1);

    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    chk("t6_q", 32'(queue_status), 32'h0e);
    cyc(0, 0, 1, 2, 0);
    chk("t6_stop", 32'(stop_req), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    cur = 0;
    repeat (3000) begin
      if (!m_serv && $urandom_range(0, 3) == 0)
        cur = $urandom_range(0, NF - 1);
      cyc($urandom_range(0, 1) == 1,
          $urandom_range(0, 7),
          $urandom_range(0, 3) == 0,
          cur,
          $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
